// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped predictor: 2-bit saturating counters, tags and branch targets.
// Lookup is combinational and sees pre-update state. One EX update per cycle, never stalls.
module branch_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [CNT_W-1:0]   branch_count_q, branch_count_d;
    logic [CNT_W-1:0]   mispred_count_q, mispred_count_d;

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]      if_tag, upd_tag;
    logic                  if_hit, upd_hit;
    logic                  wr_en;
    logic                  valid_d;
    logic [TAG_W-1:0]      tag_d;
    logic [1:0]            ctr_d;
    logic [XLEN-1:0]       target_d;
    logic [1:0]            unused_pc_bits;

    assign unused_pc_bits = upd_pc[1:0];

    assign if_idx  = if_pc[INDEX_BITS+1:2];
    assign if_tag  = if_pc[XLEN-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[XLEN-1:INDEX_BITS+2];

    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        wr_en    = 1'b0;
        valid_d  = valid_q[upd_idx];
        tag_d    = tag_q[upd_idx];
        ctr_d    = ctr_q[upd_idx];
        target_d = target_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    target_d = upd_target;
                end else begin
                    ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                wr_en    = 1'b1;
                valid_d  = 1'b1;
                tag_d    = upd_tag;
                ctr_d    = 2'b10;
                target_d = upd_target;
            end
        end
    end

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_valid) begin
            if (branch_count_q != {CNT_W{1'b1}})
                branch_count_d = branch_count_q + CNT_W'(1);
            if ((upd_pred_taken != upd_taken) && (mispred_count_q != {CNT_W{1'b1}}))
                mispred_count_d = mispred_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b01;
                target_q[i] <= '0;
            end
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[upd_idx]  <= valid_d;
                tag_q[upd_idx]    <= tag_d;
                ctr_q[upd_idx]    <= ctr_d;
                target_q[upd_idx] <= target_d;
            end
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: scoreboarded lookups plus counter model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] branch_count;
    logic [15:0] mispred_count;

    typedef struct {
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_br = 16'd0;
    logic [15:0] exp_mp = 16'd0;
    logic        pend_br = 1'b0;
    logic        pend_mp = 1'b0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .INDEX_BITS(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count)
    );

    // Drives one cycle of stimulus just after the rising edge and returns at the falling edge.
    task automatic cycle(input logic [31:0] ipc, input logic v, input logic [31:0] upc,
                         input logic t, input logic [31:0] tgt, input logic pt);
        @(posedge clk);
        if (pend_br && exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
        if (pend_mp && exp_mp != 16'hFFFF) exp_mp = exp_mp + 16'd1;
        #1;
        if_pc = ipc; upd_valid = v; upd_pc = upc; upd_taken = t;
        upd_target = tgt; upd_pred_taken = pt;
        pend_br = v;
        pend_mp = v && (pt != t);
        @(negedge clk);
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b1; if_pc = 32'h100; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back('{1'b0, 32'h104});
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken) begin errors++; $display("FAIL reset_taken got %b want %b", pred_taken, e.taken); end
        checks++;
        if (pred_target !== e.target) begin errors++; $display("FAIL reset_target got %h want %h", pred_target, e.target); end
        checks++;
        if (branch_count !== 16'd0) begin errors++; $display("FAIL reset_branch_count got %h want 0", branch_count); end
        checks++;
        if (mispred_count !== 16'd0) begin errors++; $display("FAIL reset_mispred_count got %h want 0", mispred_count); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_alloc;
        exp_t e;
        sb.push_back('{1'b0, 32'h104});
        cycle(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken || pred_target !== e.target) begin
            errors++; $display("FAIL alloc_before got %b/%h want %b/%h", pred_taken, pred_target, e.taken, e.target);
        end
        sb.push_back('{1'b1, 32'h80});
        cycle(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken || pred_target !== e.target) begin
            errors++; $display("FAIL alloc_after got %b/%h want %b/%h", pred_taken, pred_target, e.taken, e.target);
        end
        checks++;
        if (branch_count !== exp_br || mispred_count !== exp_mp) begin
            errors++; $display("FAIL alloc_counts got %h/%h want %h/%h", branch_count, mispred_count, exp_br, exp_mp);
        end
    endtask

    // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10; each lookup sees the pre-update value.
    task automatic test_ctr_dec;
        exp_t e;
        logic upd_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic upd_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic exp_t_ [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{exp_t_[i], exp_t_[i] ? 32'h80 : 32'h104});
            cycle(32'h100, upd_v[i], 32'h100, upd_t[i], 32'h80, ~upd_t[i]);
            e = sb.pop_front();
            checks++;
            if (pred_taken !== e.taken || pred_target !== e.target) begin
                errors++; $display("FAIL ctr_dec step %0d got %b/%h want %b/%h", i, pred_taken, pred_target, e.taken, e.target);
            end
        end
        checks++;
        if (branch_count !== exp_br || mispred_count !== exp_mp) begin
            errors++; $display("FAIL ctr_dec_counts got %h/%h want %h/%h", branch_count, mispred_count, exp_br, exp_mp);
        end
    endtask

    // 10 -> 11 -> 11 -> 10 -> 01; not-taken updates carry a bogus target that must be ignored.
    task automatic test_sat_inc;
        exp_t e;
        logic        upd_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        upd_t [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] tgt   [5] = '{32'h88, 32'h88, 32'h300, 32'h300, 32'h0};
        exp_t        want  [5] = '{'{1'b1, 32'h80}, '{1'b1, 32'h88}, '{1'b1, 32'h88},
                                   '{1'b1, 32'h88}, '{1'b0, 32'h104}};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(want[i]);
            cycle(32'h100, upd_v[i], 32'h100, upd_t[i], tgt[i], 1'b1);
            e = sb.pop_front();
            checks++;
            if (pred_taken !== e.taken || pred_target !== e.target) begin
                errors++; $display("FAIL sat_inc step %0d got %b/%h want %b/%h", i, pred_taken, pred_target, e.taken, e.target);
            end
        end
    endtask

    // 0x140 shares index 0 with 0x100 and evicts it; low PC bits are ignored.
    task automatic test_alias;
        exp_t e;
        logic [31:0] ipc  [4] = '{32'h100, 32'h140, 32'h100, 32'h143};
        exp_t        want [4] = '{'{1'b0, 32'h104}, '{1'b1, 32'h40}, '{1'b0, 32'h104}, '{1'b1, 32'h40}};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(want[i]);
            cycle(ipc[i], i == 0, 32'h140, 1'b1, 32'h40, 1'b0);
            e = sb.pop_front();
            checks++;
            if (pred_taken !== e.taken || pred_target !== e.target) begin
                errors++; $display("FAIL alias step %0d got %b/%h want %b/%h", i, pred_taken, pred_target, e.taken, e.target);
            end
        end
    endtask

    task automatic test_same_cycle;
        exp_t e;
        sb.push_back('{1'b0, 32'h204});
        cycle(32'h200, 1'b1, 32'h200, 1'b1, 32'h500, 1'b0);
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken || pred_target !== e.target) begin
            errors++; $display("FAIL same_cycle_now got %b/%h want %b/%h", pred_taken, pred_target, e.taken, e.target);
        end
        sb.push_back('{1'b1, 32'h500});
        cycle(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken || pred_target !== e.target) begin
            errors++; $display("FAIL same_cycle_next got %b/%h want %b/%h", pred_taken, pred_target, e.taken, e.target);
        end
    endtask

    // Miss plus not-taken must not allocate; fall-through PC wraps at 2^32.
    task automatic test_miss_nt_wrap;
        exp_t e;
        cycle(32'h10, 1'b1, 32'h10, 1'b0, 32'h900, 1'b1);
        sb.push_back('{1'b0, 32'h14});
        cycle(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken || pred_target !== e.target) begin
            errors++; $display("FAIL miss_nt got %b/%h want %b/%h", pred_taken, pred_target, e.taken, e.target);
        end
        sb.push_back('{1'b0, 32'h0});
        cycle(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (pred_taken !== e.taken || pred_target !== e.target) begin
            errors++; $display("FAIL pc_wrap got %b/%h want %b/%h", pred_taken, pred_target, e.taken, e.target);
        end
    endtask

    task automatic test_saturation;
        int n;
        cycle(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n = 32'hFFFE - int'(exp_mp);
        // Miss + not-taken at an unused slot: counts only, table untouched.
        repeat (n) cycle(32'h0, 1'b1, 32'h3C, 1'b0, 32'h0, 1'b1);
        cycle(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (branch_count !== 16'hFFFF || mispred_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got %h/%h want ffff/fffe", branch_count, mispred_count);
        end
        repeat (2) cycle(32'h0, 1'b1, 32'h3C, 1'b0, 32'h0, 1'b1);
        cycle(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (branch_count !== 16'hFFFF || mispred_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold got %h/%h want ffff/ffff", branch_count, mispred_count);
        end
    endtask

    task automatic test_mid_reset;
        cycle(32'h140, 1'b1, 32'h140, 1'b1, 32'h44, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_br = 16'd0; exp_mp = 16'd0; pend_br = 1'b0; pend_mp = 1'b0;
        checks++;
        if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            errors++; $display("FAIL midrst_counts got %h/%h want 0/0", branch_count, mispred_count);
        end
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
            errors++; $display("FAIL midrst_lookup got %b/%h want 0/00000144", pred_taken, pred_target);
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        rst = 1'b0;
        cycle(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h144 || branch_count !== 16'd0) begin
            errors++; $display("FAIL postrst got %b/%h/%h want 0/00000144/0000", pred_taken, pred_target, branch_count);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_ctr_dec();
        test_sat_inc();
        test_alias();
        test_same_cycle();
        test_miss_nt_wrap();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
